// File: rtl/avst_cmd_to_avmm_master.sv
// AVST command stream -> Avalon-MM master, with read data returned on a credit-protected AVST response FIFO.
// Optional macro RSP_OVERFLOW_CHECK_EN adds a sticky rsp_overflow_err output.
module avst_cmd_to_avmm_master #(
   parameter int AVMM_ADDR_WIDTH  = 48,
   parameter int AVMM_DATA_WIDTH  = 512,
   parameter int AVMM_BURST_WIDTH = 1,
   parameter int RSP_FIFO_DEPTH   = 16,
   parameter int CMD_WIDTH        = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + AVMM_BURST_WIDTH + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [CMD_WIDTH-1:0]         avst_avcmd_data,
   input  logic                         avst_avcmd_valid,
   output logic                         avst_avcmd_ready,
   output logic [AVMM_DATA_WIDTH-1:0]   avst_rd_rsp_data,
   output logic                         avst_rd_rsp_valid,
   input  logic                         avst_rd_rsp_ready,
   output logic [AVMM_ADDR_WIDTH-1:0]   avmm_address,
   output logic [AVMM_DATA_WIDTH-1:0]   avmm_writedata,
   output logic [AVMM_BURST_WIDTH-1:0]  avmm_burstcount,
   output logic [AVMM_DATA_WIDTH/8-1:0] avmm_byteenable,
   output logic                         avmm_read,
   output logic                         avmm_write,
   input  logic                         avmm_waitrequest,
   input  logic [AVMM_DATA_WIDTH-1:0]   avmm_readdata,
   input  logic                         avmm_readdatavalid
`ifdef RSP_OVERFLOW_CHECK_EN
   ,
   output logic                         rsp_overflow_err
`endif
);

   localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);

   logic [AVMM_ADDR_WIDTH-1:0]  cmd_addr_s;
   logic [AVMM_DATA_WIDTH-1:0]  cmd_wdata_s;
   logic [AVMM_BURST_WIDTH-1:0] cmd_burst_s;
   logic                        cmd_read_s;
   logic [CNT_W:0]              cmd_beff_s;
   logic                        credit_ok_s;
   logic                        retire_s;
   logic                        accept_s;
   logic                        pop_s;
   logic                        push_s;
   logic                        full_s;
   logic [CNT_W:0]              rsv_next_s;

   logic [AVMM_ADDR_WIDTH-1:0]  addr_r;
   logic [AVMM_DATA_WIDTH-1:0]  wdata_r;
   logic [AVMM_BURST_WIDTH-1:0] burst_r;
   logic                        read_r;
   logic                        write_r;
   logic [CNT_W-1:0]            reserved_r;
   logic [CNT_W-1:0]            count_r;
   logic [PTR_W-1:0]            wr_ptr_r;
   logic [PTR_W-1:0]            rd_ptr_r;
   logic [AVMM_DATA_WIDTH-1:0]  mem_r [RSP_FIFO_DEPTH];

   assign cmd_read_s  = avst_avcmd_data[0];
   assign cmd_burst_s = avst_avcmd_data[AVMM_BURST_WIDTH:1];
   assign cmd_wdata_s = avst_avcmd_data[AVMM_BURST_WIDTH+AVMM_DATA_WIDTH:AVMM_BURST_WIDTH+1];
   assign cmd_addr_s  = avst_avcmd_data[CMD_WIDTH-1:CMD_WIDTH-AVMM_ADDR_WIDTH];

   // Handshake, credit and FIFO control decisions for this cycle.
   always_comb begin
      cmd_beff_s  = (cmd_burst_s == '0) ? (CNT_W+1)'(1) : (CNT_W+1)'(cmd_burst_s);
      credit_ok_s = (({1'b0, reserved_r} + cmd_beff_s) <= (CNT_W+1)'(RSP_FIFO_DEPTH));
      retire_s    = (read_r | write_r) & ~avmm_waitrequest;
      avst_avcmd_ready = reset_n & (~(read_r | write_r) | retire_s) & (~cmd_read_s | credit_ok_s);
      accept_s    = avst_avcmd_valid & avst_avcmd_ready;
      full_s      = (count_r == CNT_W'(RSP_FIFO_DEPTH));
      pop_s       = (count_r != '0) & avst_rd_rsp_ready;
      push_s      = avmm_readdatavalid & (~full_s | pop_s);
      rsv_next_s  = {1'b0, reserved_r};
      if (accept_s && cmd_read_s) begin
         rsv_next_s = rsv_next_s + cmd_beff_s;
      end else begin
         rsv_next_s = rsv_next_s;
      end
      // A pop with no credit outstanding comes from a stale return; keep the counter at zero.
      if (pop_s && (reserved_r != '0)) begin
         rsv_next_s = rsv_next_s - (CNT_W+1)'(1);
      end else begin
         rsv_next_s = rsv_next_s;
      end
   end

   // Single-entry command register driving the AVMM request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_r  <= '0;
         wdata_r <= '0;
         burst_r <= '0;
         read_r  <= 1'b0;
         write_r <= 1'b0;
      end else if (accept_s) begin
         addr_r  <= cmd_addr_s;
         wdata_r <= cmd_wdata_s;
         burst_r <= cmd_burst_s;
         read_r  <= cmd_read_s;
         write_r <= ~cmd_read_s;
      end else if (retire_s) begin
         read_r  <= 1'b0;
         write_r <= 1'b0;
      end
   end

   // Credit counter and response FIFO occupancy/pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reserved_r <= '0;
         count_r    <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
      end else begin
         reserved_r <= rsv_next_s[CNT_W-1:0];
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         if (push_s && !pop_s) begin
            count_r <= count_r + CNT_W'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - CNT_W'(1);
         end
      end
   end

   // Response storage; contents are meaningless while empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= avmm_readdata;
   end

   assign avst_rd_rsp_valid = (count_r != '0);
   assign avst_rd_rsp_data  = avst_rd_rsp_valid ? mem_r[rd_ptr_r] : '0;
   assign avmm_address      = addr_r;
   assign avmm_writedata    = wdata_r;
   assign avmm_burstcount   = burst_r;
   assign avmm_byteenable   = '1;
   assign avmm_read         = read_r;
   assign avmm_write        = write_r;

`ifdef RSP_OVERFLOW_CHECK_EN
   logic overflow_err_r;

   // Sticky flag for returns that arrive with no room or no credit behind them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_err_r <= 1'b0;
      end else if (avmm_readdatavalid && ((full_s && !pop_s) || (reserved_r == '0))) begin
         overflow_err_r <= 1'b1;
      end
   end

   assign rsp_overflow_err = overflow_err_r;
`endif

endmodule

// File: tb/tb_avst_cmd_to_avmm_master.sv
// Randomized bench for avst_cmd_to_avmm_master: random commands, random slave stalls/returns and
// random response backpressure, checked against a queue-based transaction model.
module tb_avst_cmd_to_avmm_master;

   localparam int AW = 48;
   localparam int DW = 512;
   localparam int BW = 3;
   localparam int DEPTH = 16;
   localparam int CW = AW + DW + BW + 1;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] b;
      logic          r;
   } cmd_t;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [CW-1:0]   avst_avcmd_data = '0;
   logic            avst_avcmd_valid = 1'b0;
   logic            avst_avcmd_ready;
   logic [DW-1:0]   avst_rd_rsp_data;
   logic            avst_rd_rsp_valid;
   logic            avst_rd_rsp_ready = 1'b0;
   logic [AW-1:0]   avmm_address;
   logic [DW-1:0]   avmm_writedata;
   logic [BW-1:0]   avmm_burstcount;
   logic [DW/8-1:0] avmm_byteenable;
   logic            avmm_read;
   logic            avmm_write;
   logic            avmm_waitrequest = 1'b0;
   logic [DW-1:0]   avmm_readdata = '0;
   logic            avmm_readdatavalid = 1'b0;
`ifdef RSP_OVERFLOW_CHECK_EN
   logic            rsp_overflow_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   cmd_t            cur;
   cmd_t            cmdq[$];
   logic [DW-1:0]   rspq[$];
   logic [DW-1:0]   retq[$];
   int              reserved = 0;

   avst_cmd_to_avmm_master #(
      .AVMM_ADDR_WIDTH(AW), .AVMM_DATA_WIDTH(DW), .AVMM_BURST_WIDTH(BW), .RSP_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .avst_avcmd_data(avst_avcmd_data), .avst_avcmd_valid(avst_avcmd_valid),
      .avst_avcmd_ready(avst_avcmd_ready),
      .avst_rd_rsp_data(avst_rd_rsp_data), .avst_rd_rsp_valid(avst_rd_rsp_valid),
      .avst_rd_rsp_ready(avst_rd_rsp_ready),
      .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
      .avmm_burstcount(avmm_burstcount), .avmm_byteenable(avmm_byteenable),
      .avmm_read(avmm_read), .avmm_write(avmm_write), .avmm_waitrequest(avmm_waitrequest),
      .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid)
`ifdef RSP_OVERFLOW_CHECK_EN
      , .rsp_overflow_err(rsp_overflow_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int beats(input logic [BW-1:0] b);
      return (b == '0) ? 1 : int'(b);
   endfunction

   task automatic drive_cmd(input int cmd_pct);
      cur.a = {$urandom, $urandom};
      cur.d = rand_wide();
      cur.b = BW'($urandom_range(0, (1 << BW) - 1));
      cur.r = ($urandom_range(0, 99) < 60);
      avst_avcmd_data  = {cur.a, cur.d, cur.b, cur.r};
      avst_avcmd_valid = ($urandom_range(0, 99) < cmd_pct);
   endtask

   task automatic run(input int n, input int cmd_pct, input int rsp_pct, input int wait_pct, input int rdv_pct);
      bit   retire;
      bit   exp_rdy;
      cmd_t c;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val("req_pending", DW'(avmm_read | avmm_write), DW'(cmdq.size() != 0));
         if (cmdq.size() != 0) begin
            check_val("avmm_address", DW'(avmm_address), DW'(cmdq[0].a));
            check_val("avmm_writedata", avmm_writedata, cmdq[0].d);
            check_val("avmm_burstcount", DW'(avmm_burstcount), DW'(cmdq[0].b));
            check_val("avmm_read", DW'(avmm_read), DW'(cmdq[0].r));
            check_val("avmm_write", DW'(avmm_write), DW'(!cmdq[0].r));
         end
         retire  = (cmdq.size() != 0) && !avmm_waitrequest;
         exp_rdy = ((cmdq.size() == 0) || retire) && (!cur.r || (reserved + beats(cur.b) <= DEPTH));
         check_val("cmd_ready", DW'(avst_avcmd_ready), DW'(exp_rdy));
         check_val("rsp_valid", DW'(avst_rd_rsp_valid), DW'(rspq.size() != 0));
         if (rspq.size() != 0) check_val("rsp_data", avst_rd_rsp_data, rspq[0]);
         if (retire) begin
            c = cmdq.pop_front();
            if (c.r) for (int k = 0; k < beats(c.b); k++) retq.push_back(rand_wide());
         end
         if (avst_avcmd_valid && exp_rdy) begin
            cmdq.push_back(cur);
            if (cur.r) reserved += beats(cur.b);
         end
         if (rspq.size() != 0 && avst_rd_rsp_ready) begin
            void'(rspq.pop_front());
            if (reserved > 0) reserved--;
         end
         if (avmm_readdatavalid) rspq.push_back(avmm_readdata);
         @(posedge clk);
         #1;
         avmm_waitrequest  = ($urandom_range(0, 99) < wait_pct);
         avst_rd_rsp_ready = ($urandom_range(0, 99) < rsp_pct);
         if (retq.size() != 0 && $urandom_range(0, 99) < rdv_pct) begin
            avmm_readdatavalid = 1'b1;
            avmm_readdata      = retq.pop_front();
         end else begin
            avmm_readdatavalid = 1'b0;
         end
         drive_cmd(cmd_pct);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_read"}, DW'(avmm_read), '0);
      check_val({tag, "_write"}, DW'(avmm_write), '0);
      check_val({tag, "_ready"}, DW'(avst_avcmd_ready), '0);
      check_val({tag, "_rsp_valid"}, DW'(avst_rd_rsp_valid), '0);
      check_val({tag, "_rsp_data"}, avst_rd_rsp_data, '0);
      check_val({tag, "_address"}, DW'(avmm_address), '0);
      check_val({tag, "_writedata"}, avmm_writedata, '0);
`ifdef RSP_OVERFLOW_CHECK_EN
      check_val({tag, "_ovf_err"}, DW'(rsp_overflow_err), '0);
`endif
   endtask

   task automatic mid_reset();
      logic [DW-1:0] stale;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      cmdq.delete();
      rspq.delete();
      retq.delete();
      reserved = 0;
      avmm_readdatavalid = 1'b0;
      avst_rd_rsp_ready  = 1'b0;
      avmm_waitrequest   = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cur.a = 48'h40;
      cur.d = '0;
      cur.b = BW'(1);
      cur.r = 1'b1;
      avst_avcmd_data  = {cur.a, cur.d, cur.b, cur.r};
      avst_avcmd_valid = 1'b0;
`ifdef RSP_OVERFLOW_CHECK_EN
      stale = rand_wide();
      avmm_readdatavalid = 1'b1;
      avmm_readdata      = stale;
`else
      stale = '0;
`endif
      @(negedge clk);
      check_val("post_rst_ready", DW'(avst_avcmd_ready), DW'(1));
      @(posedge clk);
      #1;
      avmm_readdatavalid = 1'b0;
`ifdef RSP_OVERFLOW_CHECK_EN
      rspq.push_back(stale);
      check_val("stale_ovf_err", DW'(rsp_overflow_err), DW'(1));
`endif
   endtask

   initial begin
      cur = '{a: '0, d: '0, b: '0, r: 1'b0};
      #12;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_val("byteenable", DW'(avmm_byteenable), DW'({(DW/8){1'b1}}));
      run(300, 70, 60, 30, 70);
      run(200, 80, 0, 20, 90);
      run(200, 60, 100, 0, 100);
      run(40, 90, 0, 50, 30);
      mid_reset();
      run(300, 70, 50, 40, 60);
      run(150, 90, 0, 10, 100);
      run(300, 0, 100, 0, 100);
      check_val("drain_cmdq", DW'(cmdq.size()), '0);
      check_val("drain_retq", DW'(retq.size()), '0);
      check_val("drain_rspq", DW'(rspq.size()), '0);
      check_val("drain_reserved", DW'(reserved), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
